// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a streaming valid/ready load port
// (auto-incrementing write pointer) and a word-aligned fetch port with
// 1-cycle read latency and error flagging.
// Optional feature macro: IMEM_CHECKSUM_EN adds load_checksum, the XOR of
// every word accepted since the last accepted load_start.
module imem_loader #(
    parameter int unsigned CPU_WIDTH       = 32,
    parameter int unsigned IMEM_DEPTH_LOG2 = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic                       load_last,
    input  logic [CPU_WIDTH-1:0]       load_data,
    output logic                       load_ready,
    output logic                       load_done,
    output logic [IMEM_DEPTH_LOG2:0]   load_count,
    input  logic                       fetch_req,
    input  logic [CPU_WIDTH-1:0]       fetch_addr,
    output logic                       fetch_ready,
    output logic                       fetch_valid,
    output logic [CPU_WIDTH-1:0]       fetch_instr,
    output logic                       fetch_err
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [CPU_WIDTH-1:0]       load_checksum
`endif
);

    localparam int unsigned DEPTH = 32'd1 << IMEM_DEPTH_LOG2;
    localparam int unsigned CNT_W = IMEM_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]     wptr;
    logic [CPU_WIDTH-1:0] mem [DEPTH];

    logic start_accept;
    logic load_accept;
    logic load_exit;
    logic fetch_accept;
    logic fetch_bad;
    logic [CPU_WIDTH-1:0] fetch_word_idx;

    // Byte address to word index; misaligned or beyond the loaded image is an error.
    assign fetch_word_idx = fetch_addr >> 2;
    assign fetch_bad      = (fetch_addr[1:0] != 2'b00) ||
                            (fetch_word_idx >= CPU_WIDTH'(load_count));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; load_start outranks a same-cycle fetch in RUN.
    always_comb begin
        state_next   = state;
        load_ready   = 1'b0;
        fetch_ready  = 1'b0;
        start_accept = 1'b0;
        load_accept  = 1'b0;
        load_exit    = 1'b0;
        fetch_accept = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    start_accept = 1'b1;
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    load_accept = 1'b1;
                    if (load_last || (wptr == CNT_W'(DEPTH - 1))) begin
                        load_exit  = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                fetch_ready = !load_start;
                if (load_start) begin
                    start_accept = 1'b1;
                    state_next   = LOAD;
                end else if (fetch_req) begin
                    fetch_accept = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write pointer, image length and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            load_count <= '0;
            load_done  <= 1'b0;
        end else begin
            load_done <= load_exit;
            if (start_accept) begin
                wptr       <= '0;
                load_count <= '0;
            end else if (load_accept) begin
                wptr <= wptr + CNT_W'(1);
                if (load_exit) begin
                    load_count <= wptr + CNT_W'(1);
                end
            end
        end
    end

    // Storage array; not reset so the image survives rst.
    always_ff @(posedge clk) begin
        if (load_accept && !rst) begin
            mem[wptr[IMEM_DEPTH_LOG2-1:0]] <= load_data;
        end
    end

    // Fetch response, one cycle after acceptance; fetch_instr holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_instr <= '0;
        end else begin
            fetch_valid <= fetch_accept;
            if (fetch_accept) begin
                fetch_err   <= fetch_bad;
                fetch_instr <= fetch_bad ? '0 : mem[fetch_word_idx[IMEM_DEPTH_LOG2-1:0]];
            end else begin
                fetch_err <= 1'b0;
            end
        end
    end

`ifdef IMEM_CHECKSUM_EN
    // Running XOR of the current image, restarted on each accepted load_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_checksum <= '0;
        end else if (start_accept) begin
            load_checksum <= '0;
        end else if (load_accept) begin
            load_checksum <= load_checksum ^ load_data;
        end
    end
`endif

endmodule
